miner_uart_tx: RTL and testbench
================================

// Module: miner_uart_tx
// PURPOSE
//  Buffered UART transmitter for the SHA3-256 miner user project. Accepts status/nonce
//  bytes from miner control logic over a valid/ready handshake, queues them in a small
//  FIFO, and serialises them 8N1 (LSB first) onto an mprj_io pin. It drives the
//  management-side serial link that the testbench UART monitor samples.
// PARAMETERS
//  CLK_DIV     4167  clock cycles per bit (40 MHz / 9600 baud); legal range 2..65535
//  FIFO_DEPTH  8     byte FIFO entries; power of two, 2..16
// PORTS
//  wb_clk_i     in   1      user-area clock
//  wb_rst_i     in   1      asynchronous, active-high reset
//  enable       in   1      1 = transmitter may start new frames
//  tx_data      in   8      byte to queue
//  tx_valid     in   1      tx_data valid
//  tx_ready     out  1      FIFO can accept (level != FIFO_DEPTH)
//  uart_tx      out  1      serial line, idle high
//  uart_oeb     out  1      pad output-enable-bar, constant 0 out of reset
//  busy         out  1      frame in progress or FIFO non-empty
//  fifo_level   out  $clog2(FIFO_DEPTH)+1  entries currently queued
// BEHAVIOUR
//  - Reset (async assert, sync release): uart_tx=1, uart_oeb=0, busy=0, fifo_level=0,
//    tx_ready=1, FSM=IDLE, baud and bit counters 0, FIFO pointers 0. Mid-frame reset
//    aborts the frame; line returns high immediately; queued bytes are discarded.
//  - Push: tx_valid&&tx_ready at posedge writes tx_data. tx_ready depends only on the
//    registered level, never on same-cycle pop; push when full is ignored.
//  - Simultaneous push and pop: level unchanged, both take effect.
//  - FSM IDLE -> START when enable && level!=0: pop head into shift reg that cycle;
//    start bit (0) driven from next cycle. START -> DATA -> STOP (-> PARITY before STOP
//    when enabled). Every bit held exactly CLK_DIV cycles (baud counter reloads
//    CLK_DIV-1, advances on 0). DATA sends bit0..bit7. STOP drives 1 for CLK_DIV cycles,
//    then IDLE, or START directly (same cycle pop) if enable && level!=0: back-to-back
//    frames have no idle gap.
//  - Frame length 10*CLK_DIV cycles (11*CLK_DIV with parity).
//  - enable deasserted mid-frame: current frame completes; no new pop.
//  - busy = (state!=IDLE) || (level!=0). Pointers wrap modulo FIFO_DEPTH.
// CONFIGURATION
//  MINER_UART_PARITY_EN defined: PARITY state after bit7 sends even parity (XOR of
//  the 8 data bits), frame 8E1. Undefined: no PARITY state or logic, frame 8N1.
// STRUCTURE
//  miner_uart_pkg: FSM state enum (IDLE, START, DATA, PARITY, STOP), UART_IDLE_LVL=1,
//  UART_DATA_BITS=8, default divider constant.
//  Sub-module miner_uart_fifo: synchronous byte FIFO (push/pop/level/full/empty),
//  registered level, async active-high reset; top holds FSM, baud counter, shifter.
// TESTING (bench uses CLK_DIV=4, FIFO_DEPTH=4)
//  1 Push 0xA5, enable=1 -> uart_tx 0,1,0,1,0,0,1,0,1,1, each 4 cycles; busy low after.
//  2 Push 0x00,0xFF,0x3C back-to-back -> three frames, 120 cycles total, no idle gap,
//    decoded bytes match in order.
//  3 enable=0, push 5 bytes -> 4 accepted, tx_ready=0 at level 4, 5th dropped, line high.
//  4 At level 4 with enable=1, hold tx_valid through first pop -> push accepted only
//    the cycle after level drops to 3; level never exceeds 4.
//  5 Assert wb_rst_i during bit3 of 0x81 -> uart_tx=1 same cycle, level 0, busy 0;
//    next pushed 0x55 sends a clean frame.
//  6 MINER_UART_PARITY_EN: 0xA5 -> parity 0, 0x07 -> parity 1; frame 44 cycles.

Source files
------------

// File: rtl/miner_uart_pkg.sv
// Shared definitions for the miner UART transmitter.
//   uart_state_e         : transmitter FSM states
//   UART_IDLE_LVL        : serial line level between frames (mark)
//   UART_DATA_BITS       : data bits per frame
//   UART_CLK_DIV_DEFAULT : clocks per bit for 40 MHz / 9600 baud
// Build option: MINER_UART_PARITY_EN (see miner_uart_tx.sv) uses ST_PARITY.
package miner_uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    localparam logic UART_IDLE_LVL        = 1'b1;
    localparam int   UART_DATA_BITS       = 8;
    localparam int   UART_CLK_DIV_DEFAULT = 4167;

endpackage

// File: rtl/miner_uart_tx_if.sv
// Byte handshake between miner control logic and the UART transmitter.
//   tx_data  : byte to queue
//   tx_valid : tx_data is valid this cycle
//   tx_ready : transmitter FIFO can accept a byte
// master = byte producer, slave = transmitter.
interface miner_uart_tx_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (output tx_data, output tx_valid, input tx_ready);
    modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/miner_uart_fifo.sv
// Synchronous byte FIFO with a registered fill level.
//   clk, rst  : clock, asynchronous active-high reset
//   push      : write push_data (ignored when full)
//   pop       : drop head entry (ignored when empty)
//   pop_data  : current head entry (combinational read)
//   level     : entries currently stored
//   full      : level == DEPTH
//   empty     : level == 0
// DEPTH must be a power of two so the pointers wrap naturally.
module miner_uart_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({do_push, do_pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/miner_uart_tx.sv
// Buffered UART transmitter: queues bytes from the miner control logic and
// serialises them LSB first, 8N1 (8E1 when MINER_UART_PARITY_EN is defined).
//   wb_clk_i   : user-area clock
//   wb_rst_i   : asynchronous active-high reset (released synchronously inside)
//   enable     : 1 = new frames may start; a running frame always completes
//   tx_if      : byte handshake (slave side)
//   uart_tx    : serial line, idle high
//   uart_oeb   : pad output-enable-bar, tied low
//   busy       : frame in progress or bytes queued
//   fifo_level : bytes currently queued
// Build option: MINER_UART_PARITY_EN adds an even-parity bit after bit7.
//
// state  | meaning
// IDLE   | line high, waiting for enable and a queued byte
// START  | start bit (0)
// DATA   | data bits, shift_q[0] on the line
// PARITY | even parity of the byte (parity build only)
// STOP   | stop bit (1); may chain straight into the next START
module miner_uart_tx
    import miner_uart_pkg::*;
#(
    parameter int CLK_DIV    = UART_CLK_DIV_DEFAULT,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                        wb_clk_i,
    input  logic                        wb_rst_i,
    input  logic                        enable,
    miner_uart_tx_if.slave              tx_if,
    output logic                        uart_tx,
    output logic                        uart_oeb,
    output logic                        busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

    localparam int          BIT_W      = $clog2(UART_DATA_BITS);
    localparam logic [15:0] DIV_RELOAD = 16'(CLK_DIV - 1);

    logic [1:0]       rst_sync;
    logic             rst;
    uart_state_e      state_q;
    uart_state_e      state_d;
    logic [15:0]      baud_cnt;
    logic [BIT_W-1:0] bit_cnt;
    logic [7:0]       shift_q;
    logic             baud_tick;
    logic             last_bit;
    logic             start_ok;
    logic             pop;
    logic             tx_bit;
    logic [7:0]       head_data;
    logic             fifo_full;
    logic             fifo_empty;
`ifdef MINER_UART_PARITY_EN
    logic             parity_q;
`endif

    // Assertion reaches every flop at once; release waits two clock edges.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            rst_sync <= 2'b11;
        end else begin
            rst_sync <= {rst_sync[0], 1'b0};
        end
    end
    assign rst = rst_sync[1];

    miner_uart_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (wb_clk_i),
        .rst       (rst),
        .push      (tx_if.tx_valid),
        .push_data (tx_if.tx_data),
        .pop       (pop),
        .pop_data  (head_data),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign tx_if.tx_ready = !fifo_full;
    assign uart_oeb       = 1'b0;
    assign busy           = (state_q != ST_IDLE) || !fifo_empty;
    assign uart_tx        = tx_bit;

    assign baud_tick = (baud_cnt == '0);
    assign last_bit  = (bit_cnt == BIT_W'(UART_DATA_BITS - 1));
    assign start_ok  = enable && !fifo_empty;

    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (start_ok)  state_d = ST_START;
            ST_START:  if (baud_tick) state_d = ST_DATA;
`ifdef MINER_UART_PARITY_EN
            ST_DATA:   if (baud_tick && last_bit) state_d = ST_PARITY;
            ST_PARITY: if (baud_tick) state_d = ST_STOP;
`else
            ST_DATA:   if (baud_tick && last_bit) state_d = ST_STOP;
`endif
            ST_STOP:   if (baud_tick) state_d = start_ok ? ST_START : ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Pop happens on the cycle the FSM commits to a new frame, so the start
    // bit appears on the following cycle and stop->start has no gap.
    always_comb begin
        tx_bit = UART_IDLE_LVL;
        pop    = 1'b0;
        unique case (state_q)
            ST_IDLE:   pop    = start_ok;
            ST_START:  tx_bit = ~UART_IDLE_LVL;
            ST_DATA:   tx_bit = shift_q[0];
`ifdef MINER_UART_PARITY_EN
            ST_PARITY: tx_bit = parity_q;
`endif
            ST_STOP:   pop    = baud_tick && start_ok;
            default:   tx_bit = UART_IDLE_LVL;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            shift_q  <= '0;
        end else begin
            if (pop) begin
                baud_cnt <= DIV_RELOAD;
            end else if (state_q == ST_IDLE) begin
                baud_cnt <= '0;
            end else if (baud_tick) begin
                baud_cnt <= (state_d == ST_IDLE) ? 16'd0 : DIV_RELOAD;
            end else begin
                baud_cnt <= baud_cnt - 16'd1;
            end

            if (pop) begin
                bit_cnt <= '0;
                shift_q <= head_data;
            end else if (state_q == ST_DATA && baud_tick) begin
                bit_cnt <= bit_cnt + BIT_W'(1);
                shift_q <= {1'b0, shift_q[7:1]};
            end
        end
    end

`ifdef MINER_UART_PARITY_EN
    always_ff @(posedge wb_clk_i or posedge rst) begin
        if (rst) begin
            parity_q <= 1'b0;
        end else if (pop) begin
            parity_q <= ^head_data;
        end
    end
`endif

endmodule

// File: tb/tb_miner_uart_tx.sv
// Directed bench for miner_uart_tx (CLK_DIV=4, FIFO_DEPTH=4). Builds with or
// without MINER_UART_PARITY_EN; expected frames carry a hand-computed parity bit.
module tb_miner_uart_tx;

    localparam int DIV   = 4;
    localparam int DEPTH = 4;
`ifdef MINER_UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic       clk;
    logic       wb_rst_i;
    logic       enable;
    logic       uart_tx;
    logic       uart_oeb;
    logic       busy;
    logic [2:0] fifo_level;

    int total = 0;
    int bad   = 0;

    miner_uart_tx_if tx_if ();

    miner_uart_tx #(
        .CLK_DIV    (DIV),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (wb_rst_i),
        .enable     (enable),
        .tx_if      (tx_if),
        .uart_tx    (uart_tx),
        .uart_oeb   (uart_oeb),
        .busy       (busy),
        .fifo_level (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0]  data;
        logic [10:0] frame;  // {stop, parity, data, start}; bit0 sent first
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [10:0] mk(input logic [7:0] d, input logic p);
        return {1'b1, p, d, 1'b0};
    endfunction

    task automatic push(input logic [7:0] d);
        tx_if.tx_data  = d;
        tx_if.tx_valid = 1'b1;
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
    endtask

    task automatic wait_start(input int max_wait, input string name, output logic ok);
        int n;
        n = 0;
        @(negedge clk);
        while (uart_tx !== 1'b0 && n < max_wait) begin
            @(negedge clk);
            n++;
        end
        ok = (uart_tx === 1'b0);
        check({name, " start"}, 16'(ok), 16'd1);
    endtask

    // start_c = 0: wait (bounded) for the start bit. Otherwise the previous
    // negedge was frame cycle start_c-1 and checking resumes at cycle start_c.
    task automatic expect_frame(input logic [10:0] fr, input string name,
                                input int max_wait, input int start_c);
        logic       ok;
        logic       e;
        logic [3:0] samp;
        ok   = 1'b1;
        e    = 1'b0;
        samp = '0;
        if (start_c == 0) begin
            wait_start(max_wait, name, ok);
        end else begin
            @(negedge clk);
        end
        if (ok) begin
            for (int c = start_c; c < NB * DIV; c++) begin
                if (c != start_c) @(negedge clk);
                e = (c / DIV == NB - 1) ? 1'b1 : fr[c / DIV];
                if (c % DIV == 0 || c == start_c) samp = {4{e}};
                samp[c % DIV] = uart_tx;
                if (c % DIV == DIV - 1) begin
                    check($sformatf("%s bit%0d", name, c / DIV), 16'(samp), 16'({4{e}}));
                end
            end
        end
    endtask

    task automatic expect_idle(input string name);
        @(negedge clk);
        check({name, " busy"}, 16'(busy), 16'd0);
        check({name, " line"}, 16'(uart_tx), 16'd1);
        check({name, " level"}, 16'(fifo_level), 16'd0);
    endtask

    initial begin
        vecs[0] = '{8'hA5, {1'b1, 1'b0, 8'hA5, 1'b0}};
        vecs[1] = '{8'h00, {1'b1, 1'b0, 8'h00, 1'b0}};
        vecs[2] = '{8'hFF, {1'b1, 1'b0, 8'hFF, 1'b0}};
        vecs[3] = '{8'h3C, {1'b1, 1'b0, 8'h3C, 1'b0}};
        vecs[4] = '{8'h81, {1'b1, 1'b0, 8'h81, 1'b0}};
        vecs[5] = '{8'h55, {1'b1, 1'b0, 8'h55, 1'b0}};
        vecs[6] = '{8'h07, {1'b1, 1'b1, 8'h07, 1'b0}};

        wb_rst_i       = 1'b0;
        enable         = 1'b0;
        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b0;
        #2 wb_rst_i = 1'b1;
        #1;
        check("rst line", 16'(uart_tx), 16'd1);
        check("rst oeb", 16'(uart_oeb), 16'd0);
        check("rst busy", 16'(busy), 16'd0);
        check("rst level", 16'(fifo_level), 16'd0);
        check("rst ready", 16'(tx_if.tx_ready), 16'd1);
        repeat (2) @(negedge clk);
        wb_rst_i = 1'b0;
        repeat (3) @(negedge clk);
        check("post-rst line", 16'(uart_tx), 16'd1);

        // single frames from the table
        enable = 1'b1;
        for (int i = 0; i < 7; i++) begin
            push(vecs[i].data);
            expect_frame(vecs[i].frame, $sformatf("vec%0d", i), 10, 0);
            expect_idle($sformatf("vec%0d idle", i));
        end

        // back-to-back frames; second push coincides with the first pop
        tx_if.tx_data  = 8'h00;
        tx_if.tx_valid = 1'b1;
        @(negedge clk);
        check("b2b level after push", 16'(fifo_level), 16'd1);
        tx_if.tx_data = 8'hFF;
        @(negedge clk);
        check("b2b level push+pop", 16'(fifo_level), 16'd1);
        check("b2b start bit", 16'(uart_tx), 16'd0);
        tx_if.tx_data = 8'h3C;
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
        check("b2b level two queued", 16'(fifo_level), 16'd2);
        expect_frame(mk(8'h00, 1'b0), "b2b f0", 0, 2);
        expect_frame(mk(8'hFF, 1'b0), "b2b f1", 0, 0);
        expect_frame(mk(8'h3C, 1'b0), "b2b f2", 0, 0);
        expect_idle("b2b idle");

        // overflow with transmitter disabled
        enable         = 1'b0;
        tx_if.tx_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tx_if.tx_data = 8'h11 * 8'(i + 1);
            @(negedge clk);
            check($sformatf("ovf line %0d", i), 16'(uart_tx), 16'd1);
        end
        tx_if.tx_valid = 1'b0;
        check("ovf level", 16'(fifo_level), 16'd4);
        check("ovf ready", 16'(tx_if.tx_ready), 16'd0);
        enable = 1'b1;
        expect_frame(mk(8'h11, 1'b0), "ovf f0", 3, 0);
        expect_frame(mk(8'h22, 1'b0), "ovf f1", 0, 0);
        expect_frame(mk(8'h33, 1'b0), "ovf f2", 0, 0);
        expect_frame(mk(8'h44, 1'b0), "ovf f3", 0, 0);
        expect_idle("ovf idle");

        // full FIFO: held push lands only after level drops
        enable         = 1'b0;
        tx_if.tx_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tx_if.tx_data = 8'h61 + 8'(i);
            @(negedge clk);
        end
        check("full level", 16'(fifo_level), 16'd4);
        tx_if.tx_data = 8'h65;
        enable        = 1'b1;
        @(negedge clk);
        check("full pop level", 16'(fifo_level), 16'd3);
        check("full pop ready", 16'(tx_if.tx_ready), 16'd1);
        check("full pop start", 16'(uart_tx), 16'd0);
        @(negedge clk);
        check("full refill level", 16'(fifo_level), 16'd4);
        check("full refill ready", 16'(tx_if.tx_ready), 16'd0);
        tx_if.tx_valid = 1'b0;
        expect_frame(mk(8'h61, 1'b1), "full f0", 0, 2);
        expect_frame(mk(8'h62, 1'b1), "full f1", 0, 0);
        expect_frame(mk(8'h63, 1'b0), "full f2", 0, 0);
        expect_frame(mk(8'h64, 1'b1), "full f3", 0, 0);
        expect_frame(mk(8'h65, 1'b0), "full f4", 0, 0);
        expect_idle("full idle");

        // reset during data bit3 of 0x81 with another byte queued
        tx_if.tx_data  = 8'h81;
        tx_if.tx_valid = 1'b1;
        @(negedge clk);
        tx_if.tx_data = 8'h99;
        @(negedge clk);
        tx_if.tx_valid = 1'b0;
        check("rst-mid start", 16'(uart_tx), 16'd0);
        for (int c = 1; c <= 17; c++) @(negedge clk);
        check("rst-mid bit3", 16'(uart_tx), 16'd0);
        wb_rst_i = 1'b1;
        #1;
        check("rst-mid line", 16'(uart_tx), 16'd1);
        check("rst-mid level", 16'(fifo_level), 16'd0);
        check("rst-mid busy", 16'(busy), 16'd0);
        @(negedge clk);
        wb_rst_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst-mid idle line", 16'(uart_tx), 16'd1);
        push(8'h55);
        expect_frame(mk(8'h55, 1'b0), "rst-mid f", 10, 0);
        expect_idle("rst-mid idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
